// File: rtl/sev_seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   AN_OFF   : all-anodes-off pattern (slice to N_DIGITS bits)
//   DP_OFF   : decimal point off level (active-low output)
//   phase_e  : slot phase, BLANK (dead time) or ON
//   clog2    : constant-foldable ceil(log2(v)) for port/counter widths
package sev_seg_pkg;

  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic       DP_OFF = 1'b1;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sev_seg_scan_timer.sv
// Slot/digit timebase for the scan controller.
//   clk, reset  : clock, synchronous active-high reset
//   digit_idx   : registered index of the current slot
//   idx_nxt     : slot index that will be held after the next edge
//   phase_nxt   : slot phase that will be held after the next edge
//   slot_wrap   : high in the last cycle of a slot (next edge starts a slot)
//   frame_wrap  : high in the last cycle of the last slot (next edge enters slot 0)
// The *_nxt outputs let the parent register its outputs on the same edge the
// counter moves, so every output lines up with the cnt/digit_idx it belongs to.
module sev_seg_scan_timer
  import sev_seg_pkg::*;
#(
  parameter  int N_DIGITS     = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int IDX_W        = clog2(N_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] digit_idx,
  output logic [IDX_W-1:0] idx_nxt,
  output phase_e           phase_nxt,
  output logic             slot_wrap,
  output logic             frame_wrap
);

  localparam int CNT_W = clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign slot_wrap  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_wrap = slot_wrap && (digit_idx == IDX_W'(N_DIGITS - 1));

  always_comb begin
    cnt_nxt = slot_wrap ? '0 : cnt + 1'b1;
    idx_nxt = digit_idx;
    if (frame_wrap)     idx_nxt = '0;
    else if (slot_wrap) idx_nxt = digit_idx + 1'b1;
    phase_nxt = (cnt_nxt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_ON;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else begin
      cnt       <= cnt_nxt;
      digit_idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed scan controller for a common-anode multi-digit display.
//   clk, reset  : clock, synchronous active-high reset
//   load        : strobe, captures value_in/dp_in into the pending buffer
//   value_in    : hex value, nibble i -> digit i (digit 0 rightmost)
//   dp_in       : per-digit decimal point request, active-high
//   lz_blank_en : leading-zero blanking enable (level)
//   x_out       : nibble of the current digit, to the segment decoder
//   an          : anode enables, active-low, at most one low
//   dp          : decimal point, active-low
//   digit_idx   : current slot index
//   frame_start : one-cycle pulse on entry to slot 0
// New values sit in a pending buffer and are committed only on the frame
// wrap, so a frame never mixes old and new digits.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter  int N_DIGITS     = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int IDX_W        = clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_blank_en,
  output logic [3:0]            x_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_start
);

  logic [IDX_W-1:0] idx_nxt;
  phase_e           phase_nxt;
  logic             slot_wrap, frame_wrap;

  sev_seg_scan_timer #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .digit_idx (digit_idx),
    .idx_nxt   (idx_nxt),
    .phase_nxt (phase_nxt),
    .slot_wrap (slot_wrap),
    .frame_wrap(frame_wrap)
  );

  logic [N_DIGITS-1:0][3:0] disp, pend, disp_nxt;
  logic [N_DIGITS-1:0]      disp_dp, pend_dp, dp_nxt_v;
  logic                     pend_vld, commit;
  logic [N_DIGITS-1:0]      blank_v, one_hot;
  logic                     zero_run;

  // Old pending data commits on the wrap edge even if a new load lands on
  // that same edge; the new load simply refills pending for the next frame.
  assign commit   = frame_wrap && pend_vld;
  assign disp_nxt = commit ? pend    : disp;
  assign dp_nxt_v = commit ? pend_dp : disp_dp;

  // Digit i (i >= 1) is blank when it and every digit above it are zero.
  always_comb begin
    blank_v  = '0;
    zero_run = lz_blank_en;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (disp_nxt[i] == 4'h0);
      blank_v[i] = zero_run;
    end
  end

  always_comb begin
    one_hot          = '0;
    one_hot[idx_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp        <= '0;
      disp_dp     <= '0;
      pend        <= '0;
      pend_dp     <= '0;
      pend_vld    <= 1'b0;
      x_out       <= 4'h0;
      an          <= AN_OFF[N_DIGITS-1:0];
      dp          <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        pend     <= value_in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end else if (frame_wrap) begin
        pend_vld <= 1'b0;
      end
      disp        <= disp_nxt;
      disp_dp     <= dp_nxt_v;
      frame_start <= frame_wrap;
      // Nibble is latched at slot entry and held through BLANK and ON.
      if (slot_wrap) x_out <= disp_nxt[idx_nxt];
      if (phase_nxt == PH_BLANK || blank_v[idx_nxt]) begin
        an <= AN_OFF[N_DIGITS-1:0];
        dp <= DP_OFF;
      end else begin
        an <= ~one_hot;
        dp <= ~dp_nxt_v[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_scan.sv
module tb_sev_seg_scan;

  logic        clk = 1'b0;
  logic        reset, load, lz_blank_en;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  x_out, an;
  logic        dp, frame_start;
  logic [1:0]  digit_idx;

  sev_seg_scan #(
    .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in), .dp_in(dp_in),
    .lz_blank_en(lz_blank_en), .x_out(x_out), .an(an), .dp(dp),
    .digit_idx(digit_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         k;
    logic [3:0] an;
    logic [3:0] x;
    logic       dp;
    logic [1:0] idx;
    logic       fs;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int passes = 0;

  // Expected outputs for relative cycles k0..k1 of a known display content.
  // lit/dpm are given by hand per frame (which digits are lit, which dp on).
  task automatic exp_range(input int k0, input int k1, input logic [15:0] v,
                           input logic [3:0] lit, input logic [3:0] dpm,
                           input string nm);
    exp_t t;
    int c, d;
    logic on;
    for (int k = k0; k <= k1; k++) begin
      c     = k % 8;
      d     = (k % 32) / 8;
      on    = (c >= 2) && lit[d];
      t.cyc = base + k;
      t.k   = k;
      t.an  = on ? ~(4'b0001 << d) : 4'b1111;
      t.x   = v[d*4 +: 4];
      t.dp  = (on && dpm[d]) ? 1'b0 : 1'b1;
      t.idx = 2'(d);
      t.fs  = (k % 32 == 0) && (k != 0);
      t.nm  = nm;
      sb.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc == cyc && an === e.an && x_out === e.x && dp === e.dp &&
          digit_idx === e.idx && frame_start === e.fs) begin
        passes++;
      end else begin
        $display("FAIL %s k=%0d: got an=%b x=%h dp=%b idx=%0d fs=%b, want an=%b x=%h dp=%b idx=%0d fs=%b",
                 e.nm, e.k, an, x_out, dp, digit_idx, frame_start,
                 e.an, e.x, e.dp, e.idx, e.fs);
      end
    end
  end

  task automatic go_to(input int k);
    while (cyc < base + k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; lz_blank_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    base = cyc;

    exp_range(  0,  31, 16'h0000, 4'b1111, 4'b0000, "reset_frame");
    exp_range( 32,  63, 16'h1234, 4'b1111, 4'b0000, "show_1234");
    exp_range( 64,  95, 16'h5678, 4'b1111, 4'b0000, "newest_wins");
    exp_range( 96, 127, 16'h0042, 4'b0011, 4'b0000, "lz_0042");
    exp_range(128, 159, 16'h0000, 4'b0001, 4'b0000, "lz_0000");
    exp_range(160, 191, 16'h3141, 4'b1111, 4'b0100, "dp_slot2");
    exp_range(192, 223, 16'h2222, 4'b1111, 4'b0000, "wrap_old");
    exp_range(224, 243, 16'h7777, 4'b1111, 4'b0000, "wrap_new");

    go_to(5);   do_load(16'h1234, 4'b0000);
    go_to(42);  do_load(16'hABCD, 4'b0000);
    go_to(45);  do_load(16'h5678, 4'b0000);
    go_to(67);  lz_blank_en = 1'b1; do_load(16'h0042, 4'b0000);
    go_to(100); do_load(16'h0000, 4'b0000);
    go_to(132); do_load(16'h3141, 4'b0100);
    go_to(180); do_load(16'h2222, 4'b0000);
    go_to(191); do_load(16'h7777, 4'b0000);   // lands on the wrap edge
    go_to(240); do_load(16'hEEEE, 4'b1111);   // pending, discarded by reset
    go_to(243);                               // slot 2, cnt 3 (ON)
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    base = cyc;
    exp_range(0, 63, 16'h0000, 4'b0001, 4'b0000, "post_reset");

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
